// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back path.
package rf_pkg;

  localparam int REG_W    = 5;
  localparam int XLEN_DEF = 32;
  localparam int NREG     = 32;

  // Fixed requester slots on the write-back arbiter
  localparam int SRC_ALU = 0;
  localparam int SRC_LSU = 1;
  localparam int SRC_CSR = 2;

  typedef logic [REG_W-1:0] reg_name_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Producer-side write-back request bus: per-requester valid/ready plus packed name/data.
interface regfile_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = XLEN_DEF
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*REG_W-1:0] req_name;
  logic [NREQ*XLEN-1:0]  req_val;

  modport master (
    output req_valid,
    output req_name,
    output req_val,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_name,
    input  req_val,
    output req_ready
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant starting at ptr, ptr moves past the winner on accept.
module rr_arbiter #(
  parameter int NREQ  = 3,
  parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             accept,
  output logic [NREQ-1:0]  grant,
  output logic [PTR_W-1:0] ptr
);

  logic [PTR_W-1:0] gidx;
  logic [PTR_W-1:0] ptr_next;
  logic             found;

  function automatic logic [PTR_W-1:0] slot(input logic [PTR_W-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NREQ;
    return PTR_W'(s);
  endfunction

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req[slot(ptr, k)]) begin
        grant[slot(ptr, k)] = 1'b1;
        gidx                = slot(ptr, k);
        found               = 1'b1;
      end
    end
    // No grant may escape while the block is held in reset
    if (!rst_n) begin
      grant = '0;
      found = 1'b0;
    end
  end

  always_comb begin
    ptr_next = ptr;
    if (accept && found) begin
      ptr_next = slot(gidx, 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the regfile write port plus the RAW-hazard busy scoreboard.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int XLEN = XLEN_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  req_bus,
  input  logic                 rsv_valid,
  input  reg_name_t            rsv_name,
  input  reg_name_t            q1_name,
  input  reg_name_t            q2_name,
  output logic                 q1_busy,
  output logic                 q2_busy,
  output logic                 w_enable,
  output reg_name_t            w_reg_name,
  output logic [XLEN-1:0]      w_reg_val
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]  grant;
  logic [PTR_W-1:0] ptr;
  logic             accept;
  reg_name_t        sel_name;
  logic [XLEN-1:0]  sel_val;
  logic [NREG-1:0]  busy;
  logic [NREG-1:0]  busy_next;

  // A grant is only ever given to a valid requester, so any grant is an accept
  assign accept            = |grant;
  assign req_bus.req_ready = grant;

  rr_arbiter #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_bus.req_valid),
    .accept (accept),
    .grant  (grant),
    .ptr    (ptr)
  );

  always_comb begin
    sel_name = '0;
    sel_val  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_name = sel_name | req_bus.req_name[REG_W*i +: REG_W];
        sel_val  = sel_val  | req_bus.req_val[XLEN*i +: XLEN];
      end
    end
  end

  // Reserve is applied after clear so a younger producer keeps the bit set
  always_comb begin
    busy_next = busy;
    if (accept && (sel_name != '0)) begin
      busy_next[sel_name] = 1'b0;
    end
    if (rsv_valid && (rsv_name != '0)) begin
      busy_next[rsv_name] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  assign q1_busy = (q1_name != '0) && busy[q1_name];
  assign q2_busy = (q2_name != '0) && busy[q2_name];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_enable   <= 1'b0;
      w_reg_name <= '0;
      w_reg_val  <= '0;
    end else if (accept) begin
      w_enable   <= (sel_name != '0);
      w_reg_name <= sel_name;
      w_reg_val  <= sel_val;
    end else begin
      w_enable   <= 1'b0;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_ptr_range:    assert property (@(posedge clk) disable iff (!rst_n) int'(ptr) < NREQ);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vector table plus reset, x0 and stall sequences.
module tb_regfile_wb_arbiter;
  import rf_pkg::*;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam logic [2:0] G_ALU = 3'(1 << SRC_ALU);
  localparam logic [2:0] G_LSU = 3'(1 << SRC_LSU);
  localparam logic [2:0] G_CSR = 3'(1 << SRC_CSR);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            rsv_valid;
  reg_name_t       rsv_name, q1_name, q2_name;
  logic            q1_busy, q2_busy, w_enable;
  reg_name_t       w_reg_name;
  logic [XLEN-1:0] w_reg_val;
  logic [XLEN-1:0] rf [32];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN)) bus ();

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_bus    (bus),
    .rsv_valid  (rsv_valid),
    .rsv_name   (rsv_name),
    .q1_name    (q1_name),
    .q2_name    (q2_name),
    .q1_busy    (q1_busy),
    .q2_busy    (q2_busy),
    .w_enable   (w_enable),
    .w_reg_name (w_reg_name),
    .w_reg_val  (w_reg_val)
  );

  // Regfile write port commits on the falling edge
  always @(negedge clk) begin
    if (w_enable && (w_reg_name != 5'd0)) rf[w_reg_name] = w_reg_val;
  end

  typedef struct packed {
    logic [2:0]       valid;
    logic [2:0][4:0]  names;
    logic [2:0][31:0] vals;
    logic             rsv_v;
    logic [4:0]       rsv_n;
    logic [4:0]       q1;
    logic [4:0]       q2;
    logic [2:0]       e_ready;
    logic             e_wen;
    logic [4:0]       e_wname;
    logic [31:0]      e_wval;
    logic             e_q1;
    logic             e_q2;
    logic             rf_chk;
    logic [4:0]       rf_n;
    logic [31:0]      rf_v;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic [2:0] valid, input logic [2:0][4:0] names, input logic [2:0][31:0] vals,
    input logic rsv_v, input logic [4:0] rsv_n, input logic [4:0] q1, input logic [4:0] q2,
    input logic [2:0] e_ready, input logic e_wen, input logic [4:0] e_wname,
    input logic [31:0] e_wval, input logic e_q1, input logic e_q2,
    input logic rf_chk, input logic [4:0] rf_n, input logic [31:0] rf_v);
    vec_t v;
    v.valid = valid;  v.names = names;  v.vals = vals;
    v.rsv_v = rsv_v;  v.rsv_n = rsv_n;  v.q1 = q1;  v.q2 = q2;
    v.e_ready = e_ready;  v.e_wen = e_wen;  v.e_wname = e_wname;  v.e_wval = e_wval;
    v.e_q1 = e_q1;  v.e_q2 = e_q2;
    v.rf_chk = rf_chk;  v.rf_n = rf_n;  v.rf_v = rf_v;
    return v;
  endfunction

  task automatic check(input string what, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", what, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] valid, input logic [2:0][4:0] names,
                       input logic [2:0][31:0] vals, input logic rv, input logic [4:0] rn,
                       input logic [4:0] q1, input logic [4:0] q2);
    bus.req_valid = valid;
    bus.req_name  = names;
    bus.req_val   = vals;
    rsv_valid     = rv;
    rsv_name      = rn;
    q1_name       = q1;
    q2_name       = q2;
  endtask

  task automatic to_drive_point;
    @(posedge clk);
    #1;
  endtask

  task automatic to_check_point;
    @(negedge clk);
    #1;
  endtask

  logic [2:0][4:0]  nm_rr, nm_hz, nm_ss, nm_x0, nm_st;
  logic [2:0][31:0] vl_rr, vl_hz, vl_ss, vl_x0, vl_st;
  logic             any_busy;

  initial begin
    nm_rr = {5'd7, 5'd6, 5'd5};   vl_rr = {32'hA2, 32'hA1, 32'hA0};
    nm_hz = {5'd7, 5'd10, 5'd5};  vl_hz = {32'hA2, 32'hDEADBEEF, 32'hA0};
    nm_ss = {5'd3, 5'd10, 5'd5};  vl_ss = {32'h33, 32'hDEADBEEF, 32'hA0};
    nm_x0 = {5'd7, 5'd0, 5'd5};   vl_x0 = {32'hA2, 32'h1234, 32'hA0};
    nm_st = {5'd9, 5'd11, 5'd8};  vl_st = {32'hCAFE0002, 32'hCAFE0001, 32'hCAFE0000};

    //            valid   names  vals   rsv      q1     q2     ready  wen name   val          q1b q2b rf
    vecs[0]  = mk(3'b111, nm_rr, vl_rr, 0, 5'd0, 5'd0,  5'd0,  G_ALU, 0, 5'd0,  32'h0,       0, 0, 0, 5'd0,  32'h0);
    vecs[1]  = mk(3'b111, nm_rr, vl_rr, 0, 5'd0, 5'd0,  5'd0,  G_LSU, 1, 5'd5,  32'hA0,      0, 0, 1, 5'd5,  32'hA0);
    vecs[2]  = mk(3'b111, nm_rr, vl_rr, 0, 5'd0, 5'd0,  5'd0,  G_CSR, 1, 5'd6,  32'hA1,      0, 0, 1, 5'd6,  32'hA1);
    vecs[3]  = mk(3'b111, nm_rr, vl_rr, 0, 5'd0, 5'd0,  5'd0,  G_ALU, 1, 5'd7,  32'hA2,      0, 0, 1, 5'd7,  32'hA2);
    vecs[4]  = mk(3'b111, nm_rr, vl_rr, 0, 5'd0, 5'd0,  5'd0,  G_LSU, 1, 5'd5,  32'hA0,      0, 0, 0, 5'd0,  32'h0);
    vecs[5]  = mk(3'b111, nm_rr, vl_rr, 0, 5'd0, 5'd0,  5'd0,  G_CSR, 1, 5'd6,  32'hA1,      0, 0, 0, 5'd0,  32'h0);
    vecs[6]  = mk(3'b000, nm_rr, vl_rr, 0, 5'd0, 5'd0,  5'd0,  3'b000, 1, 5'd7, 32'hA2,      0, 0, 0, 5'd0,  32'h0);
    vecs[7]  = mk(3'b000, nm_rr, vl_rr, 0, 5'd0, 5'd0,  5'd0,  3'b000, 0, 5'd7, 32'hA2,      0, 0, 0, 5'd0,  32'h0);
    vecs[8]  = mk(3'b000, nm_rr, vl_rr, 1, 5'd10, 5'd10, 5'd0, 3'b000, 0, 5'd7, 32'hA2,      0, 0, 0, 5'd0,  32'h0);
    vecs[9]  = mk(3'b010, nm_hz, vl_hz, 0, 5'd0, 5'd10, 5'd11, G_LSU, 0, 5'd7,  32'hA2,      1, 0, 0, 5'd0,  32'h0);
    vecs[10] = mk(3'b000, nm_hz, vl_hz, 1, 5'd3, 5'd10, 5'd3,  3'b000, 1, 5'd10, 32'hDEADBEEF, 0, 0, 1, 5'd10, 32'hDEADBEEF);
    vecs[11] = mk(3'b100, nm_ss, vl_ss, 1, 5'd3, 5'd3,  5'd10, G_CSR, 0, 5'd10, 32'hDEADBEEF, 1, 0, 0, 5'd0,  32'h0);
    vecs[12] = mk(3'b000, nm_ss, vl_ss, 0, 5'd0, 5'd3,  5'd10, 3'b000, 1, 5'd3, 32'h33,      1, 0, 1, 5'd3,  32'h33);
    vecs[13] = mk(3'b000, nm_ss, vl_ss, 0, 5'd0, 5'd3,  5'd0,  3'b000, 0, 5'd3, 32'h33,      1, 0, 0, 5'd0,  32'h0);

    for (int r = 0; r < 32; r++) rf[r] = '0;

    // Power-on reset with all requesters asserting
    rst_n = 1'b0;
    drive(3'b111, nm_rr, vl_rr, 1'b0, 5'd0, 5'd0, 5'd0);
    to_check_point();
    check("por req_ready", 64'(bus.req_ready), 64'(3'b000));
    check("por w_enable", 64'(w_enable), 64'(1'b0));
    check("por w_reg_name", 64'(w_reg_name), 64'(5'd0));
    check("por w_reg_val", 64'(w_reg_val), 64'(32'h0));
    drive(3'b000, nm_rr, vl_rr, 1'b0, 5'd0, 5'd0, 5'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      to_drive_point();
      drive(vecs[i].valid, vecs[i].names, vecs[i].vals, vecs[i].rsv_v, vecs[i].rsv_n,
            vecs[i].q1, vecs[i].q2);
      to_check_point();
      check($sformatf("v%0d req_ready", i), 64'(bus.req_ready), 64'(vecs[i].e_ready));
      check($sformatf("v%0d w_enable", i), 64'(w_enable), 64'(vecs[i].e_wen));
      check($sformatf("v%0d w_reg_name", i), 64'(w_reg_name), 64'(vecs[i].e_wname));
      check($sformatf("v%0d w_reg_val", i), 64'(w_reg_val), 64'(vecs[i].e_wval));
      check($sformatf("v%0d q1_busy", i), 64'(q1_busy), 64'(vecs[i].e_q1));
      check($sformatf("v%0d q2_busy", i), 64'(q2_busy), 64'(vecs[i].e_q2));
      if (vecs[i].rf_chk)
        check($sformatf("v%0d rf[x%0d]", i, vecs[i].rf_n), 64'(rf[vecs[i].rf_n]), 64'(vecs[i].rf_v));
    end

    // Mid-operation reset: a write is in flight, x3 is busy and ptr has moved to 1
    to_drive_point();
    drive(3'b001, {5'd7, 5'd6, 5'd4}, {32'hA2, 32'hA1, 32'h44}, 1'b0, 5'd0, 5'd3, 5'd0);
    to_drive_point();
    drive(3'b111, nm_rr, vl_rr, 1'b0, 5'd0, 5'd3, 5'd0);
    check("pre-reset w_enable", 64'(w_enable), 64'(1'b1));
    check("pre-reset q1_busy x3", 64'(q1_busy), 64'(1'b1));
    #1;
    rst_n = 1'b0;
    #1;
    check("mid reset req_ready", 64'(bus.req_ready), 64'(3'b000));
    check("mid reset w_enable", 64'(w_enable), 64'(1'b0));
    check("mid reset w_reg_name", 64'(w_reg_name), 64'(5'd0));
    check("mid reset w_reg_val", 64'(w_reg_val), 64'(32'h0));
    any_busy = 1'b0;
    for (int r = 0; r < 32; r++) begin
      q1_name = 5'(r);
      #1;
      any_busy = any_busy | q1_busy;
    end
    check("mid reset any busy", 64'(any_busy), 64'(1'b0));
    q1_name = 5'd3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post reset first grant", 64'(bus.req_ready), 64'(G_ALU));

    // x0 write by the LSU consumes the grant but issues no write
    to_drive_point();
    drive(3'b010, nm_x0, vl_x0, 1'b0, 5'd0, 5'd0, 5'd0);
    to_check_point();
    check("x0 req_ready", 64'(bus.req_ready), 64'(G_LSU));
    check("x0 prior w_reg_name", 64'(w_reg_name), 64'(5'd5));
    to_drive_point();
    drive(3'b111, nm_x0, vl_x0, 1'b1, 5'd0, 5'd0, 5'd0);
    to_check_point();
    check("x0 w_enable", 64'(w_enable), 64'(1'b0));
    check("x0 w_reg_name", 64'(w_reg_name), 64'(5'd0));
    check("x0 w_reg_val", 64'(w_reg_val), 64'(32'h1234));
    check("x0 ptr advanced to 2", 64'(bus.req_ready), 64'(G_CSR));
    to_drive_point();
    drive(3'b000, nm_x0, vl_x0, 1'b0, 5'd0, 5'd0, 5'd0);
    to_check_point();
    check("x0 q1_busy", 64'(q1_busy), 64'(1'b0));
    check("x0 next write x7", 64'(w_reg_name), 64'(5'd7));

    // CSR held valid behind ALU and LSU keeps its data until its grant
    to_drive_point();
    drive(3'b111, nm_st, vl_st, 1'b0, 5'd0, 5'd0, 5'd0);
    to_check_point();
    check("stall c0 req_ready", 64'(bus.req_ready), 64'(G_ALU));
    to_drive_point();
    drive(3'b110, nm_st, vl_st, 1'b0, 5'd0, 5'd0, 5'd0);
    to_check_point();
    check("stall c1 req_ready", 64'(bus.req_ready), 64'(G_LSU));
    check("stall c1 w_reg_name", 64'(w_reg_name), 64'(5'd8));
    to_drive_point();
    drive(3'b100, nm_st, vl_st, 1'b0, 5'd0, 5'd0, 5'd0);
    to_check_point();
    check("stall c2 req_ready", 64'(bus.req_ready), 64'(G_CSR));
    check("stall c2 w_reg_val", 64'(w_reg_val), 64'(32'hCAFE0001));
    to_drive_point();
    drive(3'b000, nm_st, vl_st, 1'b0, 5'd0, 5'd0, 5'd0);
    to_check_point();
    check("stall c3 w_enable", 64'(w_enable), 64'(1'b1));
    check("stall c3 w_reg_name", 64'(w_reg_name), 64'(5'd9));
    check("stall c3 w_reg_val", 64'(w_reg_val), 64'(32'hCAFE0002));
    check("stall c3 rf[x9]", 64'(rf[9]), 64'(32'hCAFE0002));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
